// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register for the MIPS ALU: decodes opcode/funct and registers the operands and control.
// Optional performance counters are enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm16,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [2:0]        ex_alu_control,
    output logic [4:0]        ex_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_issued,
    output logic [CNT_W-1:0]  perf_bubbles,
    output logic [CNT_W-1:0]  perf_stalls
`endif
);

    logic [DATA_W-1:0] sign_ext, zero_ext;
    logic [DATA_W-1:0] dec_b;
    logic [2:0]        dec_ctrl;
    logic [4:0]        dec_dst;
    logic              dec_rw, dec_mr, dec_mw, dec_br, dec_ill;
    logic              load, bubble;

    logic              valid_reg, rw_reg, mr_reg, mw_reg, br_reg, ill_reg;
    logic [DATA_W-1:0] a_reg, b_reg;
    logic [2:0]        ctrl_reg;
    logic [4:0]        dst_reg;

    assign sign_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    assign zero_ext = {{(DATA_W-16){1'b0}}, imm16};

    assign in_ready = ~stall;
    assign load     = in_valid & ~stall & ~flush;
    assign bubble   = flush | (~stall & ~in_valid);

    always_comb begin
        dec_ctrl = 3'b010;
        dec_b    = rt_data;
        dec_dst  = 5'd0;
        dec_rw   = 1'b0;
        dec_mr   = 1'b0;
        dec_mw   = 1'b0;
        dec_br   = 1'b0;
        dec_ill  = 1'b0;
        case (opcode)
            6'b000000: begin
                dec_dst = rd;
                dec_rw  = 1'b1;
                case (funct)
                    6'b100000, 6'b100001: dec_ctrl = 3'b010;
                    6'b100010, 6'b100011: dec_ctrl = 3'b110;
                    6'b100100:            dec_ctrl = 3'b000;
                    6'b100101:            dec_ctrl = 3'b001;
                    6'b101010:            dec_ctrl = 3'b111;
                    default: begin
                        dec_dst = 5'd0;
                        dec_rw  = 1'b0;
                        dec_ill = 1'b1;
                    end
                endcase
            end
            6'b001000: begin dec_b = sign_ext; dec_dst = rt; dec_rw = 1'b1; end
            6'b001010: begin dec_ctrl = 3'b111; dec_b = sign_ext; dec_dst = rt; dec_rw = 1'b1; end
            6'b001100: begin dec_ctrl = 3'b000; dec_b = zero_ext; dec_dst = rt; dec_rw = 1'b1; end
            6'b001101: begin dec_ctrl = 3'b001; dec_b = zero_ext; dec_dst = rt; dec_rw = 1'b1; end
            6'b100011: begin dec_b = sign_ext; dec_dst = rt; dec_rw = 1'b1; dec_mr = 1'b1; end
            6'b101011: begin dec_b = sign_ext; dec_mw = 1'b1; end
            6'b000100: begin dec_ctrl = 3'b110; dec_br = 1'b1; end
            default:   dec_ill = 1'b1;
        endcase
    end

    // Flush wins over stall; a stall without flush simply keeps every register.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            valid_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            ctrl_reg  <= 3'b000;
            dst_reg   <= 5'd0;
            rw_reg    <= 1'b0;
            mr_reg    <= 1'b0;
            mw_reg    <= 1'b0;
            br_reg    <= 1'b0;
            ill_reg   <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            a_reg     <= rs_data;
            b_reg     <= dec_b;
            ctrl_reg  <= dec_ctrl;
            dst_reg   <= dec_dst;
            rw_reg    <= dec_rw & (dec_dst != 5'd0);
            mr_reg    <= dec_mr;
            mw_reg    <= dec_mw;
            br_reg    <= dec_br;
            ill_reg   <= dec_ill;
        end
    end

    assign ex_valid       = valid_reg;
    assign ex_a           = a_reg;
    assign ex_b           = b_reg;
    assign ex_alu_control = ctrl_reg;
    assign ex_dst         = dst_reg;
    assign ex_reg_write   = rw_reg;
    assign ex_mem_read    = mr_reg;
    assign ex_mem_write   = mw_reg;
    assign ex_branch      = br_reg;
    assign ex_illegal     = ill_reg;

`ifdef ALU_ISSUE_PERF_EN
    logic [2:0] perf_evt;
    assign perf_evt = {stall & ~flush, bubble, load};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (reset)
                cnt_reg <= '0;
            else if (perf_evt[gi])
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign perf_issued  = g_cnt[0].cnt_reg;
    assign perf_bubbles = g_cnt[1].cnt_reg;
    assign perf_stalls  = g_cnt[2].cnt_reg;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed steps plus random traffic against an instruction-level model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, stall, flush;
    logic [5:0]  opcode, funct;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm16;
    logic [4:0]  rt, rd;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
    logic [31:0] ex_a, ex_b;
    logic [2:0]  ex_alu_control;
    logic [4:0]  ex_dst;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_bubbles, perf_stalls;
    int unsigned m_issued, m_bubbles, m_stalls;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data),
        .imm16(imm16), .rt(rt), .rd(rd), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_control(ex_alu_control),
        .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_issued(perf_issued), .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls)
`endif
    );

    typedef struct {
        logic        v;
        logic [31:0] a, b;
        logic [2:0]  c;
        logic [4:0]  d;
        logic        rw, mr, mw, br, il;
        logic        chk_b;
    } exp_t;

    exp_t exp_s;

    // Instruction-level reference: what the EX stage should hold for one accepted instruction.
    function automatic exp_t decode(input logic [5:0] op, input logic [5:0] fn,
                                    input logic [31:0] rs, input logic [31:0] rtd,
                                    input logic [15:0] imm, input logic [4:0] rtn,
                                    input logic [4:0] rdn);
        exp_t e;
        logic [31:0] sx, zx;
        sx = 32'($signed(imm));
        zx = {16'h0000, imm};
        e = '{v: 1'b1, a: rs, b: 32'h0, c: 3'b010, d: 5'd0, rw: 1'b0, mr: 1'b0,
              mw: 1'b0, br: 1'b0, il: 1'b0, chk_b: 1'b1};
        if (op == 6'd0) begin
            e.b = rtd; e.d = rdn; e.rw = 1'b1;
            if (fn == 6'h20 || fn == 6'h21)      e.c = 3'b010;
            else if (fn == 6'h22 || fn == 6'h23) e.c = 3'b110;
            else if (fn == 6'h24)                e.c = 3'b000;
            else if (fn == 6'h25)                e.c = 3'b001;
            else if (fn == 6'h2a)                e.c = 3'b111;
            else begin e.il = 1'b1; e.d = 5'd0; e.rw = 1'b0; e.chk_b = 1'b0; end
        end else if (op == 6'h08) begin e.b = sx; e.d = rtn; e.rw = 1'b1; end
        else if (op == 6'h0a) begin e.c = 3'b111; e.b = sx; e.d = rtn; e.rw = 1'b1; end
        else if (op == 6'h0c) begin e.c = 3'b000; e.b = zx; e.d = rtn; e.rw = 1'b1; end
        else if (op == 6'h0d) begin e.c = 3'b001; e.b = zx; e.d = rtn; e.rw = 1'b1; end
        else if (op == 6'h23) begin e.b = sx; e.d = rtn; e.rw = 1'b1; e.mr = 1'b1; end
        else if (op == 6'h2b) begin e.b = sx; e.mw = 1'b1; end
        else if (op == 6'h04) begin e.c = 3'b110; e.b = rtd; e.br = 1'b1; end
        else begin e.il = 1'b1; e.chk_b = 1'b0; end
        if (e.d == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic exp_t zero_state();
        return '{v: 1'b0, a: 32'h0, b: 32'h0, c: 3'b000, d: 5'd0, rw: 1'b0, mr: 1'b0,
                 mw: 1'b0, br: 1'b0, il: 1'b0, chk_b: 1'b1};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rtd, input logic [15:0] imm,
                         input logic [4:0] rtn, input logic [4:0] rdn,
                         input logic st, input logic fl);
        in_valid = v; opcode = op; funct = fn; rs_data = rs; rt_data = rtd;
        imm16 = imm; rt = rtn; rd = rdn; stall = st; flush = fl;
    endtask

    // One clock: check in_ready, advance the model on the edge, then compare every output.
    task automatic step(input string tag);
        #1;
        check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ~stall});
        @(posedge clk);
        if (reset) exp_s = zero_state();
        else if (flush) exp_s = zero_state();
        else if (stall) exp_s = exp_s;
        else if (!in_valid) exp_s = zero_state();
        else exp_s = decode(opcode, funct, rs_data, rt_data, imm16, rt, rd);
`ifdef ALU_ISSUE_PERF_EN
        if (reset) begin m_issued = 0; m_bubbles = 0; m_stalls = 0; end
        else begin
            if (flush || (!stall && !in_valid)) m_bubbles++;
            else if (stall) m_stalls++;
            else m_issued++;
        end
`endif
        #1;
        check({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, exp_s.v});
        check({tag, ".a"}, ex_a, exp_s.a);
        if (exp_s.chk_b) check({tag, ".b"}, ex_b, exp_s.b);
        check({tag, ".ctrl"}, {29'd0, ex_alu_control}, {29'd0, exp_s.c});
        check({tag, ".dst"}, {27'd0, ex_dst}, {27'd0, exp_s.d});
        check({tag, ".ctl"}, {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal},
              {27'd0, exp_s.rw, exp_s.mr, exp_s.mw, exp_s.br, exp_s.il});
`ifdef ALU_ISSUE_PERF_EN
        check({tag, ".perf_issued"}, perf_issued, m_issued);
        check({tag, ".perf_bubbles"}, perf_bubbles, m_bubbles);
        check({tag, ".perf_stalls"}, perf_stalls, m_stalls);
`endif
        $display("step %-10s v=%0d a=%h b=%h ctrl=%b dst=%0d rw=%0d mr=%0d mw=%0d br=%0d ill=%0d",
                 tag, ex_valid, ex_a, ex_b, ex_alu_control, ex_dst, ex_reg_write,
                 ex_mem_read, ex_mem_write, ex_branch, ex_illegal);
    endtask

    logic [5:0] ops [10];
    logic [5:0] fns [7];
    logic [5:0] op_r, fn_r;

    initial begin
        exp_s = zero_state();
        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h04};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a};

        // Reset for two cycles with random inputs applied.
        reset = 1'b1;
        drive(1'b1, 6'($urandom), 6'($urandom), $urandom, $urandom, 16'($urandom),
              5'($urandom), 5'($urandom), 1'b0, 1'b0);
        step("reset0");
        drive(1'b1, 6'($urandom), 6'($urandom), $urandom, $urandom, 16'($urandom),
              5'($urandom), 5'($urandom), 1'b0, 1'b0);
        step("reset1");
        check("reset.ctrl000", {29'd0, ex_alu_control}, 32'd0);
        reset = 1'b0;

        drive(1'b1, 6'h00, 6'h22, 32'd5, 32'd3, 16'h0000, 5'd3, 5'd9, 1'b0, 1'b0);
        step("sub");
        check("sub.ctrl", {29'd0, ex_alu_control}, 32'd6);

        drive(1'b1, 6'h08, 6'h00, 32'd1, 32'd0, 16'hFFFF, 5'd4, 5'd0, 1'b0, 1'b0);
        step("addi");
        check("addi.b", ex_b, 32'hFFFF_FFFF);
        drive(1'b1, 6'h0d, 6'h00, 32'd1, 32'd0, 16'hFFFF, 5'd4, 5'd0, 1'b0, 1'b0);
        step("ori");
        check("ori.b", ex_b, 32'h0000_FFFF);

        drive(1'b1, 6'h23, 6'h00, 32'h100, 32'd0, 16'h0010, 5'd7, 5'd0, 1'b0, 1'b0);
        step("lw");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'h00, 6'h20, 32'hDEAD, 32'hBEEF, 16'h1234, 5'd1, 5'd2, 1'b1, 1'b0);
            step("lw_stall");
        end
        check("lw_stall.mem_read", {31'd0, ex_mem_read}, 32'd1);

        drive(1'b1, 6'h00, 6'h20, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 1'b1, 1'b1);
        step("stallflush");

        drive(1'b1, 6'h3f, 6'h00, 32'd11, 32'd12, 16'h0, 5'd1, 5'd2, 1'b0, 1'b0);
        step("illegal");
        drive(1'b1, 6'h00, 6'h20, 32'd11, 32'd12, 16'h0, 5'd1, 5'd0, 1'b0, 1'b0);
        step("add_rd0");
        drive(1'b1, 6'h2b, 6'h00, 32'd8, 32'd9, 16'h8000, 5'd6, 5'd0, 1'b0, 1'b0);
        step("sw");
        drive(1'b0, 6'h00, 6'h20, 32'd8, 32'd9, 16'h0, 5'd6, 5'd1, 1'b0, 1'b0);
        step("idle");

        // Random traffic, occasional unknown opcodes/functs and hazards.
        for (int i = 0; i < 300; i++) begin
            op_r = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            fn_r = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            drive($urandom_range(0, 3) != 0, op_r, fn_r, $urandom, $urandom, 16'($urandom),
                  5'($urandom), 5'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
